// File: rtl/sparse_event_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : sparse_event_encoder_if
// Brief    : Address-event output stream (valid/ready) of the sparse encoder.
// Revision : 1.0
// ============================================================================
interface sparse_event_encoder_if #(
    parameter int DW = 3
);
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface
`default_nettype wire

// File: rtl/sparse_event_encoder.sv
`default_nettype none
// ============================================================================
// Module   : sparse_event_encoder
// Brief    : Captures a sparse event vector and streams set-bit indices,
//            lowest first, through a small FIFO. Optional timestamp prefix
//            enabled by defining EVENT_TIMESTAMP_EN.
// Revision : 1.0
// ============================================================================
module sparse_event_encoder #(
    parameter int N_IN       = 8,
    parameter int ADDR_W     = $clog2(N_IN),
    parameter int FIFO_DEPTH = 4,
    parameter int TS_W       = 4
) (
    input  wire logic                        clk,
    input  wire logic                        rst_n,
    input  wire logic                        ena,
    input  wire logic [N_IN-1:0]             in_vec,
    input  wire logic                        in_strobe,
    sparse_event_encoder_if.master           evt,
    output logic                             busy,
    output logic                             overflow,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_count
);
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
`ifdef EVENT_TIMESTAMP_EN
    localparam int c_dw = TS_W + ADDR_W;
`else
    localparam int c_dw = ADDR_W;
`endif

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_SCAN = 1'b1} state_t;

    state_t               r_state, w_state_nxt;
    logic [N_IN-1:0]      r_pending, w_pending_nxt, w_low_bit, w_cleared;
    logic [ADDR_W-1:0]    w_low_idx;
    logic                 w_push, w_pop, w_full, w_valid, w_ovf_set;
    logic [c_dw-1:0]      r_mem [FIFO_DEPTH];
    logic [c_dw-1:0]      w_push_data;
    logic [c_ptr_w-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_ptr_w:0]     r_count;
    logic                 r_overflow;

    // Isolate the lowest set bit; the index search runs high-to-low so the
    // last hit wins.
    assign w_low_bit = r_pending & (~r_pending + N_IN'(1));
    always_comb begin
        w_low_idx = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (r_pending[i]) w_low_idx = ADDR_W'(i);
        end
    end

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == (c_ptr_w + 1)'(FIFO_DEPTH));
    assign w_pop   = w_valid & evt.out_ready;
    assign w_push  = ena && (r_state == S_SCAN) && (!w_full || w_pop);

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_ovf_set     = 1'b0;
        w_cleared     = w_push ? w_low_bit : '0;
        if (ena) begin
            case (r_state)
                S_IDLE: begin
                    if (in_strobe) begin
                        w_pending_nxt = in_vec;
                        w_state_nxt   = (in_vec != '0) ? S_SCAN : S_IDLE;
                    end
                end
                S_SCAN: begin
                    w_pending_nxt = r_pending & ~w_cleared;
                    if (in_strobe) begin
                        w_pending_nxt = w_pending_nxt | in_vec;
                        w_ovf_set     = |(in_vec & r_pending);
                    end
                    w_state_nxt = (w_pending_nxt == '0) ? S_IDLE : S_SCAN;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            if (w_ovf_set) r_overflow <= 1'b1;
        end
    end

`ifdef EVENT_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts, r_ts_cap;

    // Any accepted strobe (fresh or merging) retimes the remaining events.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ts     <= '0;
            r_ts_cap <= '0;
        end else if (ena) begin
            r_ts <= r_ts + TS_W'(1);
            if (in_strobe) r_ts_cap <= r_ts;
        end
    end
    assign w_push_data = {r_ts_cap, w_low_idx};
`else
    assign w_push_data = w_low_idx;
`endif

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head is masked while empty so the stream reads zero after reset.
    assign evt.out_data  = w_valid ? r_mem[r_rd_ptr] : '0;
    assign evt.out_valid = w_valid;
    assign busy          = (r_state == S_SCAN);
    assign overflow      = r_overflow;
    assign fifo_count    = r_count;
endmodule
`default_nettype wire

// File: tb/tb_sparse_event_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sparse_event_encoder
// Brief    : Scoreboard bench for sparse_event_encoder (optional timestamp).
// Revision : 1.0
// ============================================================================
module tb_sparse_event_encoder;
    localparam int N_IN       = 8;
    localparam int ADDR_W     = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int TS_W       = 4;
`ifdef EVENT_TIMESTAMP_EN
    localparam int DW = TS_W + ADDR_W;
`else
    localparam int DW = ADDR_W;
`endif

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [TS_W-1:0]   ts;
        bit                chk_ts;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n, ena, in_strobe;
    logic [N_IN-1:0] in_vec;
    logic            busy, overflow;
    logic [2:0]      fifo_count;
    logic [TS_W-1:0] m_ts;
    exp_t            sb[$];
    int              checks = 0;
    int              errors = 0;

    sparse_event_encoder_if #(.DW(DW)) evt ();

    sparse_event_encoder #(
        .N_IN(N_IN), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .TS_W(TS_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_vec(in_vec),
        .in_strobe(in_strobe), .evt(evt), .busy(busy),
        .overflow(overflow), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Reference free-running timestamp: value seen at an edge is the capture value.
    always @(posedge clk) begin
        if (!rst_n)   m_ts <= '0;
        else if (ena) m_ts <= m_ts + 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int a, input int ts = 0, input bit chk_ts = 1'b0);
        exp_t e;
        e.addr   = ADDR_W'(a);
        e.ts     = TS_W'(ts);
        e.chk_ts = chk_ts;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || evt.out_valid || busy) && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_left"}, 32'(sb.size()), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Pop side: a handshake seen at negedge completes at the next posedge.
    always @(negedge clk) begin
        if (rst_n && evt.out_valid && evt.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_pop", 32'(evt.out_data), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pop_addr", 32'(evt.out_data[ADDR_W-1:0]), 32'(e.addr));
`ifdef EVENT_TIMESTAMP_EN
                if (e.chk_ts) check("pop_ts", 32'(evt.out_data[DW-1:ADDR_W]), 32'(e.ts));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1; in_strobe = 1'b0; in_vec = '0; evt.out_ready = 1'b0;
        tick(); tick();
        check("rst_valid", 32'(evt.out_valid), 32'd0);
        check("rst_data",  32'(evt.out_data),  32'd0);
        check("rst_busy",  32'(busy),          32'd0);
        check("rst_ovf",   32'(overflow),      32'd0);
        check("rst_count", 32'(fifo_count),    32'd0);
        rst_n = 1'b1;
        tick();

        // Two sparse events, consumer always ready
        evt.out_ready = 1'b1;
        in_vec = 8'b0010_0100; in_strobe = 1'b1;
        expect_ev(2); expect_ev(5);
        tick();
        in_strobe = 1'b0;
        check("t1_no_push_capture", 32'(evt.out_valid), 32'd0);
        check("t1_busy_scan", 32'(busy), 32'd1);
        tick();
        check("t1_first_data", 32'(evt.out_data), 32'd2);
        tick();
        check("t1_second_data", 32'(evt.out_data), 32'd5);
        check("t1_busy_done", 32'(busy), 32'd0);
        wait_drain("t1");
        check("t1_ovf", 32'(overflow), 32'd0);

        // Full vector against a stalled consumer
        evt.out_ready = 1'b0;
        in_vec = 8'hFF; in_strobe = 1'b1;
        for (int i = 0; i < 8; i++) expect_ev(i);
        tick();
        in_strobe = 1'b0;
        repeat (5) tick();
        check("t2_full_count", 32'(fifo_count), 32'd4);
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_pending_hold", 32'(dut.r_pending), 32'hF0);
        check("t2_head_stable", 32'(evt.out_data), 32'd0);
        evt.out_ready = 1'b1;
        tick();
        check("t2_full_push_pop", 32'(fifo_count), 32'd4);
        wait_drain("t2");

        // Coalesced strobe while the scan is stalled by a full FIFO
        evt.out_ready = 1'b0;
        in_vec = 8'h0F; in_strobe = 1'b1;
        for (int i = 0; i < 4; i++) expect_ev(i);
        tick();
        in_strobe = 1'b0;
        repeat (4) tick();
        check("t3_full_idle", 32'(busy), 32'd0);
        in_vec = 8'h01; in_strobe = 1'b1;
        expect_ev(0);
        tick();
        in_vec = 8'h81;
        expect_ev(7);
        tick();
        in_strobe = 1'b0;
        check("t3_ovf_set", 32'(overflow), 32'd1);
        check("t3_merged", 32'(dut.r_pending), 32'h81);
        evt.out_ready = 1'b1;
        wait_drain("t3");
        check("t3_ovf_sticky", 32'(overflow), 32'd1);

        // Enable gating: no capture while disabled, pops continue mid-scan
        ena = 1'b0; in_vec = 8'h10; in_strobe = 1'b1;
        tick(); tick();
        in_strobe = 1'b0;
        check("t4_no_capture_valid", 32'(evt.out_valid), 32'd0);
        check("t4_no_capture_busy", 32'(busy), 32'd0);
        ena = 1'b1;
        in_vec = 8'h0E; in_strobe = 1'b1;
        expect_ev(1); expect_ev(2); expect_ev(3);
        tick();
        in_strobe = 1'b0;
        tick();
        ena = 1'b0;
        tick(); tick();
        check("t4_pending_frozen", 32'(dut.r_pending), 32'h0C);
        check("t4_busy_frozen", 32'(busy), 32'd1);
        check("t4_popped_while_off", 32'(fifo_count), 32'd0);
        ena = 1'b1;
        wait_drain("t4");

        // Reset in the middle of a scan with three queued events
        evt.out_ready = 1'b0;
        in_vec = 8'hFF; in_strobe = 1'b1;
        tick();
        in_strobe = 1'b0;
        repeat (3) tick();
        check("t5_count3", 32'(fifo_count), 32'd3);
        rst_n = 1'b0;
        tick();
        check("t5_valid", 32'(evt.out_valid), 32'd0);
        check("t5_data",  32'(evt.out_data),  32'd0);
        check("t5_busy",  32'(busy),          32'd0);
        check("t5_ovf",   32'(overflow),      32'd0);
        check("t5_count", 32'(fifo_count),    32'd0);
        check("t5_state", 32'(dut.r_state),   32'd0);
        rst_n = 1'b1;
        tick();

`ifdef EVENT_TIMESTAMP_EN
        begin
            int n;
            evt.out_ready = 1'b1;
            n = 0;
            while (m_ts != 4'hE && n < 40) begin tick(); n++; end
            check("t6_reach_E", 32'(m_ts), 32'hE);
            in_vec = 8'h03; in_strobe = 1'b1;
            expect_ev(0, 14, 1'b1); expect_ev(1, 14, 1'b1);
            tick();
            in_strobe = 1'b0;
            wait_drain("t6a");
            n = 0;
            while (m_ts != 4'hF && n < 40) begin tick(); n++; end
            check("t6_reach_F", 32'(m_ts), 32'hF);
            in_vec = 8'h01; in_strobe = 1'b1;
            expect_ev(0, 15, 1'b1);
            tick();
            in_vec = 8'h02;
            expect_ev(1, 0, 1'b1);
            tick();
            in_strobe = 1'b0;
            wait_drain("t6b");
            check("t6_ovf", 32'(overflow), 32'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
